// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: MDOp codes and FSM states.
package muldiv_unit_pkg;

    localparam int unsigned MDOP_W = 3;

    localparam logic [MDOP_W-1:0] MDOp_MULT  = 3'b000;
    localparam logic [MDOP_W-1:0] MDOp_MULTU = 3'b001;
    localparam logic [MDOP_W-1:0] MDOp_DIV   = 3'b010;
    localparam logic [MDOP_W-1:0] MDOp_DIVU  = 3'b011;
    localparam logic [MDOP_W-1:0] MDOp_MTHI  = 3'b100;
    localparam logic [MDOP_W-1:0] MDOp_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_step.sv
// One iteration of the multiplier (shift-add) or restoring divider on a {hi,lo} pair.
// Divider half is only built when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] op_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] hi_mul;
    logic [WIDTH-1:0] lo_mul;

    // Multiply: conditionally add multiplicand, then shift {carry,hi,lo} right.
    always_comb begin
        add_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, op_i} : {(WIDTH+1){1'b0}});
        hi_mul  = add_sum[WIDTH:1];
        lo_mul  = {add_sum[0], lo_i[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Divide: remainder always stays below the divisor, so a WIDTH-bit difference suffices.
    always_comb begin
        rem_sh = {hi_i, lo_i[WIDTH-1]};
        fits   = rem_sh >= {1'b0, op_i};
        diff   = rem_sh[WIDTH-1:0] - op_i;
        hi_o   = hi_mul;
        lo_o   = lo_mul;
        if (is_div) begin
            hi_o = fits ? diff : rem_sh[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], fits};
        end
    end
`else
    logic unused_is_div;
    assign unused_is_div = is_div;

    always_comb begin
        hi_o = hi_mul;
        lo_o = lo_mul;
    end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit with start/busy handshake and MTHI/MTLO writes.
// Define MULDIV_DIV_EN to build the DIV/DIVU path; otherwise those ops are ignored.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        MDOp,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  HI,
    output logic [WIDTH-1:0]  LO
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef MULDIV_DIV_EN
    logic               div_q, div_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               step_is_div;
    assign step_is_div = div_q;
`else
    logic               step_is_div;
    assign step_is_div = 1'b0;
`endif

    logic               op_signed_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [WIDTH-1:0]   step_hi_c;
    logic [WIDTH-1:0]   step_lo_c;
    logic [2*WIDTH-1:0] prod_c;

    assign op_signed_c = (MDOp == MDOp_MULT) || (MDOp == MDOp_DIV);
    assign a_mag_c     = (op_signed_c && A[WIDTH-1]) ? -A : A;
    assign b_mag_c     = (op_signed_c && B[WIDTH-1]) ? -B : B;
    assign prod_c      = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (step_is_div),
        .hi_i   (acc_hi_q),
        .lo_i   (acc_lo_q),
        .op_i   (opb_q),
        .hi_o   (step_hi_c),
        .lo_o   (step_lo_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_raw_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MULDIV_DIV_EN
            div_q     <= div_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            a_raw_q   <= a_raw_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef MULDIV_DIV_EN
        div_d     = div_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        a_raw_d   = a_raw_q;
`endif

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    case (MDOp)
                        // Multiplier sits in lo and is consumed LSB-first.
                        MDOp_MULT, MDOp_MULTU: begin
                            acc_hi_d = '0;
                            acc_lo_d = b_mag_c;
                            opb_d    = a_mag_c;
                            neg_d    = op_signed_c && (A[WIDTH-1] ^ B[WIDTH-1]);
                            cnt_d    = '0;
                            busy_d   = 1'b1;
                            state_d  = MD_CALC;
`ifdef MULDIV_DIV_EN
                            div_d    = 1'b0;
`endif
                        end
`ifdef MULDIV_DIV_EN
                        MDOp_DIV, MDOp_DIVU: begin
                            acc_hi_d  = '0;
                            acc_lo_d  = a_mag_c;
                            opb_d     = b_mag_c;
                            neg_d     = op_signed_c && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_rem_d = op_signed_c && A[WIDTH-1];
                            div0_d    = (B == '0);
                            a_raw_d   = A;
                            div_d     = 1'b1;
                            cnt_d     = '0;
                            busy_d    = 1'b1;
                            state_d   = MD_CALC;
                        end
`endif
                        MDOp_MTHI: begin
                            hi_d   = A;
                            done_d = 1'b1;
                        end
                        MDOp_MTLO: begin
                            lo_d   = A;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            MD_CALC: begin
                acc_hi_d = step_hi_c;
                acc_lo_d = step_lo_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MD_FIX;
                end
            end

            MD_FIX: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    // Divide by zero reports the raw dividend, not the sign-fixed iteration result.
                    if (div0_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = neg_q ? -acc_lo_q : acc_lo_q;
                        hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                    end
                end else
`endif
                begin
                    hi_d = prod_c[2*WIDTH-1:WIDTH];
                    lo_d = prod_c[WIDTH-1:0];
                end
            end

            default: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO, a monitor checks on each done.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   done_seen = 0;
    exp_t sb_q[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_seen++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {HI, LO}, {hi_m, lo_m});
                total_cnt++;
                $display("FAIL unexpected_done: done=1 with no outstanding request");
            end else begin
                e = sb_q.pop_front();
                chk("hi", 64'(HI), 64'(e.hi));
                chk("lo", 64'(LO), 64'(e.lo));
            end
        end
    end

    // Drive one start pulse (E0 is the posedge in between), then scramble operands.
    task automatic go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        A     = ~a;
        B     = b ^ 32'h5a5a_a5a5;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_iter(input string name, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el);
        int n;
`ifndef MULDIV_DIV_EN
        if (op == MDOp_DIV || op == MDOp_DIVU) begin
            go(op, a, b);
            chk({name, "_busy_ignored"}, 64'(busy), 64'd0);
            repeat (40) @(negedge clk);
            chk({name, "_hi_kept"}, 64'(HI), 64'(hi_m));
            chk({name, "_lo_kept"}, 64'(LO), 64'(lo_m));
            return;
        end
`endif
        sb_q.push_back('{hi: eh, lo: el});
        go(op, a, b);
        chk({name, "_busy"}, 64'(busy), 64'd1);
        wait_done(n);
        chk({name, "_latency"}, 64'(n), 64'd33);
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
        hi_m = eh;
        lo_m = el;
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int seen0;
        rst   = 1'b1;
        start = 1'b0;
        MDOp  = '0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi",   64'(HI),   64'd0);
        chk("rst_lo",   64'(LO),   64'd0);
        rst = 1'b0;

        run_iter("mult_neg",  MDOp_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_iter("multu_max", MDOp_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_iter("div_m7_2",  MDOp_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_iter("div_ovf",   MDOp_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_iter("div_7_m2",  MDOp_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_iter("divu_7_0",  MDOp_DIVU,  32'd7,        32'd0,        32'h0000_0007, 32'hFFFF_FFFF);
        run_iter("div_m5_0",  MDOp_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_iter("divu_100_7",MDOp_DIVU,  32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E);

        // MTLO issued at E5 of a MULT must be dropped.
        sb_q.push_back('{hi: 32'h0000_0001, lo: 32'h2345_0000});
        go(MDOp_MULT, 32'h0001_2345, 32'h0001_0000);
        repeat (4) @(negedge clk);
        start = 1'b1;
        MDOp  = MDOp_MTLO;
        A     = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_busy", 64'(busy), 64'd1);
        wait_done(n);
        hi_m = 32'h0000_0001;
        lo_m = 32'h2345_0000;
        repeat (3) @(negedge clk);
        chk("ignored_final_lo", 64'(LO), 64'(lo_m));
        chk("ignored_queue_empty", 64'(sb_q.size()), 64'd0);

        // Reset at E10 of a DIV aborts it with no done.
        seen0 = done_seen;
        go(MDOp_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi",   64'(HI),   64'd0);
        chk("abort_lo",   64'(LO),   64'd0);
        hi_m = '0;
        lo_m = '0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_seen - seen0), 64'd0);

        // Back-to-back MTHI/MTLO.
        seen0 = done_seen;
        sb_q.push_back('{hi: 32'hDEAD_BEEF, lo: 32'h0000_0000});
        sb_q.push_back('{hi: 32'hDEAD_BEEF, lo: 32'h0BAD_F00D});
        @(negedge clk);
        start = 1'b1;
        MDOp  = MDOp_MTHI;
        A     = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd1);
        MDOp  = MDOp_MTLO;
        A     = 32'h0BAD_F00D;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("mt_busy_after", 64'(busy), 64'd0);
        chk("mt_done_count", 64'(done_seen - seen0), 64'd2);

        // rst and start together: rst wins.
        rst   = 1'b1;
        start = 1'b1;
        MDOp  = MDOp_MTHI;
        A     = 32'h0000_0001;
        @(negedge clk);
        chk("rst_start_hi",   64'(HI),   64'd0);
        chk("rst_start_done", 64'(done), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
